frame_buffer_scheduler: RTL and testbench
=========================================

# frame_buffer_scheduler

Double-buffer ownership controller between the camera-side AXI4 DDR writer and the HDMI-side DDR reader. It decides which of the two DDR frame buffers each side may touch and swaps them only at frame boundaries, so the reader never displays a half-written frame. It drops or repeats whole frames when the camera rate and the display rate differ, and it aborts writer frames that stall. It sits in the `clk_100Mhz` domain next to the writer and reader.

## Interface
- `BUF0_ADDR`, default 32'h0100_0000: DDR base address of buffer 0.
- `BUF1_ADDR`, default 32'h0110_0000: DDR base address of buffer 1.
- `WR_TIMEOUT`, default 23'd4_000_000: maximum cycles from writer frame start to `writer_done`.

Ports (clock and reset first):
- `clk_100Mhz`, in, 1: the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cam_frame_start`, in, 1: 1-cycle pulse at the start of a camera frame, already synchronised.
- `writer_done`, in, 1: 1-cycle pulse; the current writer frame is fully in DDR.
- `rd_frame_req`, in, 1: level. The reader wants a buffer for its next frame and holds it high until `rd_frame_ack`.
- `wr_frame_en`, out, 1: writer may accept pixels for this frame; gates `pixel_valid`.
- `wr_abort`, out, 1: 1-cycle pulse; the writer must flush its FIFO and reset `ADDR_OFFSET`.
- `wr_buf_select`, out, 1: 1 means the writer targets BUF0, 0 means BUF1 (writer polarity).
- `wr_base_addr`, out, 32: base address of the back buffer.
- `rd_base_addr`, out, 32: base address of the front buffer.
- `rd_frame_ack`, out, 1: 1-cycle pulse; `rd_base_addr` and `rd_frame_valid` are valid for this frame.
- `rd_frame_valid`, out, 1: front buffer holds a complete frame; when 0 the reader outputs black.
- `skip_cnt`, out, 16: camera frames dropped (saturating).
- `repeat_cnt`, out, 16: display frames repeated (saturating).
- `abort_cnt`, out, 8: writer timeouts (saturating).

## Operation
- Internal registers:
  - `front` (1 bit): index of the buffer the reader owns.
  - `back`: always `~front`.
  - `has_front`: the front buffer holds a complete frame.
  - `tmo_cnt` (23 bits).
- States:
  - W_IDLE: back buffer is free; waiting for a camera frame.
  - FILL: writer is active in the back buffer.
  - READY: back buffer is complete; waiting for a swap.
- Reset values:
  - State W_IDLE; `front`=0, `has_front`=0.
  - `wr_frame_en`, `wr_abort`, `rd_frame_ack`, `rd_frame_valid` = 0; all counters = 0.
  - `wr_buf_select`=0 (back buffer is BUF1), `wr_base_addr`=`BUF1_ADDR`, `rd_base_addr`=`BUF0_ADDR`.
- W_IDLE:
  - `cam_frame_start` → FILL; set `wr_frame_en`=1; clear `tmo_cnt`.
- FILL:
  - `writer_done` → READY; clear `wr_frame_en`.
  - Otherwise, if `tmo_cnt` == `WR_TIMEOUT`-1 → W_IDLE: clear `wr_frame_en`, pulse `wr_abort`, increment `abort_cnt`. The back buffer is discarded and `front` is unchanged.
  - `cam_frame_start` while in FILL is ignored, with no counter change.
- READY:
  - `cam_frame_start` with no swap in the same cycle → stay in READY; increment `skip_cnt`.
- Reader request: `rd_frame_req` is sampled only when `rd_frame_ack`=0.
  - Swap condition: state is READY, or state is FILL with `writer_done` in the same cycle.
  - If the swap condition holds: `front` <= `back`, `has_front` <= 1, ack, and go to W_IDLE.
  - If the swap condition does not hold: ack with the current front buffer. Increment `repeat_cnt` if `has_front`=1.
- Swap in the same cycle as `cam_frame_start`: go to FILL, not W_IDLE. `wr_frame_en`=1 into the new back buffer, with no skip counted.
- `writer_done` in W_IDLE or READY is ignored.
- `wr_buf_select`, `wr_base_addr` and `rd_base_addr` change only on a swap.

## Timing
- All outputs are registered.
- `rd_frame_ack` rises on cycle N+1 for `rd_frame_req` sampled at cycle N. `rd_base_addr` and `rd_frame_valid` carry their new values on that same cycle N+1.
- After an ack the reader drops `rd_frame_req` within 1 cycle. A request still high in the ack cycle is not re-sampled.
- `wr_frame_en` rises 1 cycle after the accepted `cam_frame_start` and falls 1 cycle after `writer_done` or timeout.
- `wr_abort` is high in the same cycle that `wr_frame_en` falls on timeout.
- `rst_n` low mid-frame: all outputs take their reset values at the next edge. A frame in progress is lost, and the writer is responsible for its own reset.
- All counters saturate at their maximum value; they do not wrap.

## Configuration
- `FB_STATS_EN`:
  - Defined: `skip_cnt`, `repeat_cnt` and `abort_cnt` count as described above.
  - Undefined: the counter registers are not built and all three ports are tied to 0. Sequencing is identical.

## Test plan
- Reset, then `rd_frame_req` → ack 1 cycle later; `rd_frame_valid`=0; `rd_base_addr`=32'h0100_0000; `repeat_cnt`=0.
- `cam_frame_start`, `writer_done` 100 cycles later, then `rd_frame_req` → swap:
  - `rd_base_addr`=32'h0110_0000, `rd_frame_valid`=1.
  - `wr_base_addr`=32'h0100_0000, `wr_buf_select`=1.
- Reach READY, then 3 `cam_frame_start` pulses before any request → `skip_cnt`=3; `wr_frame_en` stays 0; buffers unchanged.
- `rd_frame_req` and `cam_frame_start` in the same cycle while READY → swap, state FILL, `wr_frame_en`=1 next cycle, `skip_cnt` unchanged.
- With `WR_TIMEOUT`=1000: `cam_frame_start` and no `writer_done` → at cycle 1000 `wr_abort` pulses once; `abort_cnt`=1; `rd_base_addr` unchanged.
- `rst_n` low while in FILL → next cycle `wr_frame_en`=0, `rd_base_addr`=32'h0100_0000, counters=0.

Source files
------------

// File: rtl/frame_buffer_scheduler.sv
// Double-buffer ownership controller between the camera DDR writer and the HDMI DDR reader.
// Optional statistics counters are built only when FB_STATS_EN is defined.
module frame_buffer_scheduler #(
  parameter logic [31:0] BUF0_ADDR  = 32'h0100_0000,
  parameter logic [31:0] BUF1_ADDR  = 32'h0110_0000,
  parameter logic [22:0] WR_TIMEOUT = 23'd4_000_000
) (
  input  logic        clk_100Mhz,
  input  logic        rst_n,
  input  logic        cam_frame_start,
  input  logic        writer_done,
  input  logic        rd_frame_req,
  output logic        wr_frame_en,
  output logic        wr_abort,
  output logic        wr_buf_select,
  output logic [31:0] wr_base_addr,
  output logic [31:0] rd_base_addr,
  output logic        rd_frame_ack,
  output logic        rd_frame_valid,
  output logic [15:0] skip_cnt,
  output logic [15:0] repeat_cnt,
  output logic [7:0]  abort_cnt
);

  typedef enum logic [1:0] {W_IDLE, FILL, READY} state_t;

  state_t      state_q, state_d;
  logic        front_q, front_d;
  logic        has_front_q, has_front_d;
  logic [22:0] tmo_cnt_q, tmo_cnt_d;
  logic        wr_frame_en_q, wr_frame_en_d;
  logic        wr_abort_q, wr_abort_d;
  logic        rd_frame_ack_q, rd_frame_ack_d;
  logic [31:0] wr_base_addr_q, wr_base_addr_d;
  logic [31:0] rd_base_addr_q, rd_base_addr_d;

  logic sample;
  logic swap;
  logic tmo_hit;

  // A request is not re-sampled in the cycle its ack is being presented.
  assign sample  = rd_frame_req && !rd_frame_ack_q;
  assign swap    = sample && ((state_q == READY) || ((state_q == FILL) && writer_done));
  assign tmo_hit = (tmo_cnt_q == WR_TIMEOUT - 23'd1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    front_d        = front_q;
    has_front_d    = has_front_q;
    tmo_cnt_d      = tmo_cnt_q;
    wr_frame_en_d  = wr_frame_en_q;
    wr_abort_d     = 1'b0;
    rd_frame_ack_d = sample;
    wr_base_addr_d = wr_base_addr_q;
    rd_base_addr_d = rd_base_addr_q;

    if (swap) begin
      front_d        = ~front_q;
      has_front_d    = 1'b1;
      rd_base_addr_d = front_q ? BUF0_ADDR : BUF1_ADDR;
      wr_base_addr_d = front_q ? BUF1_ADDR : BUF0_ADDR;
      // A camera frame arriving with the swap starts straight into the freed buffer.
      if (cam_frame_start) begin
        state_d       = FILL;
        wr_frame_en_d = 1'b1;
        tmo_cnt_d     = '0;
      end else begin
        state_d       = W_IDLE;
        wr_frame_en_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        W_IDLE: begin
          if (cam_frame_start) begin
            state_d       = FILL;
            wr_frame_en_d = 1'b1;
            tmo_cnt_d     = '0;
          end
        end
        FILL: begin
          if (writer_done) begin
            state_d       = READY;
            wr_frame_en_d = 1'b0;
          end else if (tmo_hit) begin
            state_d       = W_IDLE;
            wr_frame_en_d = 1'b0;
            wr_abort_d    = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 23'd1;
          end
        end
        READY: ;
        default: state_d = W_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch; state uses <= only.
  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state_q        <= W_IDLE;
      front_q        <= 1'b0;
      has_front_q    <= 1'b0;
      tmo_cnt_q      <= '0;
      wr_frame_en_q  <= 1'b0;
      wr_abort_q     <= 1'b0;
      rd_frame_ack_q <= 1'b0;
      wr_base_addr_q <= BUF1_ADDR;
      rd_base_addr_q <= BUF0_ADDR;
    end else begin
      state_q        <= state_d;
      front_q        <= front_d;
      has_front_q    <= has_front_d;
      tmo_cnt_q      <= tmo_cnt_d;
      wr_frame_en_q  <= wr_frame_en_d;
      wr_abort_q     <= wr_abort_d;
      rd_frame_ack_q <= rd_frame_ack_d;
      wr_base_addr_q <= wr_base_addr_d;
      rd_base_addr_q <= rd_base_addr_d;
    end
  end

  assign wr_frame_en    = wr_frame_en_q;
  assign wr_abort       = wr_abort_q;
  assign wr_buf_select  = front_q;
  assign wr_base_addr   = wr_base_addr_q;
  assign rd_base_addr   = rd_base_addr_q;
  assign rd_frame_ack   = rd_frame_ack_q;
  assign rd_frame_valid = has_front_q;

`ifdef FB_STATS_EN
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [15:0] repeat_cnt_q, repeat_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;
  logic        skip_inc, repeat_inc, abort_inc;

  assign skip_inc   = (state_q == READY) && cam_frame_start && !swap;
  assign repeat_inc = sample && !swap && has_front_q;
  assign abort_inc  = (state_q == FILL) && !writer_done && tmo_hit;

  // Counters saturate rather than wrap.
  always_comb begin
    skip_cnt_d   = skip_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    if (skip_inc && (skip_cnt_q != '1))     skip_cnt_d   = skip_cnt_q + 16'd1;
    if (repeat_inc && (repeat_cnt_q != '1)) repeat_cnt_d = repeat_cnt_q + 16'd1;
    if (abort_inc && (abort_cnt_q != '1))   abort_cnt_d  = abort_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      skip_cnt_q   <= '0;
      repeat_cnt_q <= '0;
      abort_cnt_q  <= '0;
    end else begin
      skip_cnt_q   <= skip_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign skip_cnt   = skip_cnt_q;
  assign repeat_cnt = repeat_cnt_q;
  assign abort_cnt  = abort_cnt_q;
`else
  assign skip_cnt   = '0;
  assign repeat_cnt = '0;
  assign abort_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler: directed scenarios then random traffic,
// every cycle compared against a buffer-ownership model of the scheduler.
module tb_frame_buffer_scheduler;

  localparam logic [31:0] B0  = 32'h0100_0000;
  localparam logic [31:0] B1  = 32'h0110_0000;
  localparam int          TMO = 1000;
`ifdef FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_100Mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_frame_start = 1'b0;
  logic        writer_done = 1'b0;
  logic        rd_frame_req = 1'b0;
  logic        wr_frame_en, wr_abort, wr_buf_select, rd_frame_ack, rd_frame_valid;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [15:0] skip_cnt, repeat_cnt;
  logic [7:0]  abort_cnt;

  frame_buffer_scheduler #(
    .BUF0_ADDR (B0),
    .BUF1_ADDR (B1),
    .WR_TIMEOUT(23'd1000)
  ) dut (
    .clk_100Mhz    (clk_100Mhz),
    .rst_n         (rst_n),
    .cam_frame_start(cam_frame_start),
    .writer_done   (writer_done),
    .rd_frame_req  (rd_frame_req),
    .wr_frame_en   (wr_frame_en),
    .wr_abort      (wr_abort),
    .wr_buf_select (wr_buf_select),
    .wr_base_addr  (wr_base_addr),
    .rd_base_addr  (rd_base_addr),
    .rd_frame_ack  (rd_frame_ack),
    .rd_frame_valid(rd_frame_valid),
    .skip_cnt      (skip_cnt),
    .repeat_cnt    (repeat_cnt),
    .abort_cnt     (abort_cnt)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns which buffer and what the back buffer currently holds.
  typedef enum {BK_FREE, BK_FILLING, BK_COMPLETE} back_t;
  logic [31:0] bufs [2];
  int    cyc = 0;
  int    m_front;
  bit    m_has_front;
  back_t m_back;
  int    m_start;
  bit    m_en, m_abort, m_ack;
  int    m_skip, m_rep, m_abt;

  task automatic model_reset();
    m_front = 0; m_has_front = 0; m_back = BK_FREE; m_start = 0;
    m_en = 0; m_abort = 0; m_ack = 0; m_skip = 0; m_rep = 0; m_abt = 0;
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  task automatic model_step();
    bit take, give_new;
    if (!rst_n) begin
      model_reset();
      return;
    end
    take     = rd_frame_req && !m_ack;
    give_new = take && (m_back == BK_COMPLETE || (m_back == BK_FILLING && writer_done));
    m_ack    = take;
    m_abort  = 0;
    if (give_new) begin
      m_front     = 1 - m_front;
      m_has_front = 1;
      if (cam_frame_start) begin
        m_back = BK_FILLING; m_start = cyc; m_en = 1;
      end else begin
        m_back = BK_FREE; m_en = 0;
      end
    end else begin
      if (take && m_has_front) m_rep = sat_inc(m_rep, 65535);
      if (m_back == BK_FREE) begin
        if (cam_frame_start) begin
          m_back = BK_FILLING; m_start = cyc; m_en = 1;
        end
      end else if (m_back == BK_FILLING) begin
        if (writer_done) begin
          m_back = BK_COMPLETE; m_en = 0;
        end else if (cyc - m_start == TMO) begin
          m_back = BK_FREE; m_en = 0; m_abort = 1;
          m_abt = sat_inc(m_abt, 255);
        end
      end else if (cam_frame_start) begin
        m_skip = sat_inc(m_skip, 65535);
      end
    end
  endtask

  task automatic compare_all();
    check("wr_frame_en", 32'(wr_frame_en), 32'(m_en));
    check("wr_abort", 32'(wr_abort), 32'(m_abort));
    check("rd_frame_ack", 32'(rd_frame_ack), 32'(m_ack));
    check("rd_frame_valid", 32'(rd_frame_valid), 32'(m_has_front));
    check("wr_buf_select", 32'(wr_buf_select), 32'(m_front == 1));
    check("rd_base_addr", rd_base_addr, bufs[m_front]);
    check("wr_base_addr", wr_base_addr, bufs[1 - m_front]);
    check("skip_cnt", 32'(skip_cnt), STATS ? 32'(m_skip) : 32'd0);
    check("repeat_cnt", 32'(repeat_cnt), STATS ? 32'(m_rep) : 32'd0);
    check("abort_cnt", 32'(abort_cnt), STATS ? 32'(m_abt) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk_100Mhz);
    cyc++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_cam();
    cam_frame_start = 1; tick(); cam_frame_start = 0;
  endtask

  task automatic pulse_done();
    writer_done = 1; tick(); writer_done = 0;
  endtask

  task automatic request_frame();
    bit got;
    got = 0;
    rd_frame_req = 1;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      got = rd_frame_ack;
    end
    rd_frame_req = 0;
    check("ack_within_bound", 32'(got), 32'd1);
  endtask

  initial begin
    int aborts;
    bufs[0] = B0;
    bufs[1] = B1;
    model_reset();

    // Reset state
    rst_n = 0;
    ticks(3);
    check("reset_rd_base", rd_base_addr, 32'h0100_0000);
    check("reset_wr_base", wr_base_addr, 32'h0110_0000);
    rst_n = 1;
    tick();

    // Request with no frame yet: black, buffer 0
    request_frame();
    check("first_ack_valid", 32'(rd_frame_valid), 32'd0);
    check("first_ack_rd_base", rd_base_addr, 32'h0100_0000);
    check("first_ack_repeat", 32'(repeat_cnt), 32'd0);
    tick();

    // Full frame then swap
    pulse_cam();
    check("wr_en_after_start", 32'(wr_frame_en), 32'd1);
    ticks(99);
    pulse_done();
    check("wr_en_after_done", 32'(wr_frame_en), 32'd0);
    ticks(3);
    request_frame();
    check("swap_rd_base", rd_base_addr, 32'h0110_0000);
    check("swap_valid", 32'(rd_frame_valid), 32'd1);
    check("swap_wr_base", wr_base_addr, 32'h0100_0000);
    check("swap_wr_sel", 32'(wr_buf_select), 32'd1);
    tick();

    // READY then three dropped camera frames
    pulse_cam();
    ticks(10);
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      pulse_cam();
      ticks(5);
    end
    check("skip_three", 32'(skip_cnt), STATS ? 32'd3 : 32'd0);
    check("skip_wr_en_low", 32'(wr_frame_en), 32'd0);
    check("skip_rd_base", rd_base_addr, 32'h0110_0000);

    // Request and camera start together while READY
    rd_frame_req = 1; cam_frame_start = 1;
    tick();
    rd_frame_req = 0; cam_frame_start = 0;
    check("sim_ack", 32'(rd_frame_ack), 32'd1);
    check("sim_wr_en", 32'(wr_frame_en), 32'd1);
    check("sim_rd_base", rd_base_addr, 32'h0100_0000);
    check("sim_skip", 32'(skip_cnt), STATS ? 32'd3 : 32'd0);

    // Writer stalls in that frame until the timeout fires
    aborts = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      tick();
      if (wr_abort) aborts++;
    end
    check("abort_pulses", 32'(aborts), 32'd1);
    check("abort_cnt", 32'(abort_cnt), STATS ? 32'd1 : 32'd0);
    check("abort_rd_base", rd_base_addr, 32'h0100_0000);

    // Reset mid-frame
    pulse_cam();
    ticks(20);
    rst_n = 0;
    tick();
    check("rst_wr_en", 32'(wr_frame_en), 32'd0);
    check("rst_rd_base", rd_base_addr, 32'h0100_0000);
    check("rst_skip", 32'(skip_cnt), 32'd0);
    check("rst_abort", 32'(abort_cnt), 32'd0);
    rst_n = 1;
    tick();

    // Random traffic
    for (int i = 0; i < 30000; i++) begin
      cam_frame_start = ($urandom_range(0, 39) == 0);
      writer_done     = ($urandom_range(0, 49) == 0);
      rst_n           = ($urandom_range(0, 4999) != 0);
      tick();
      if (rd_frame_ack)      rd_frame_req = ($urandom_range(0, 3) == 0);
      else if (!rd_frame_req) rd_frame_req = ($urandom_range(0, 29) == 0);
    end
    cam_frame_start = 0; writer_done = 0; rd_frame_req = 0; rst_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
